// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU arbiter slice.
// Op codes, FSM states and flag bit positions.
package alu_ctrl_pkg;

  localparam logic [2:0] OP_ADD = 3'd0;
  localparam logic [2:0] OP_SUB = 3'd1;
  localparam logic [2:0] OP_AND = 3'd2;
  localparam logic [2:0] OP_OR  = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;

  localparam int FLAG_N = 3;
  localparam int FLAG_Z = 2;
  localparam int FLAG_C = 1;
  localparam int FLAG_V = 0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  function automatic logic op_legal(
    input logic [2:0] op,
    input int         num_ops
  );
    return int'(op) < num_ops;
  endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: add, sub, and, or, xor.
// Flags {N,Z,C,V}; C on sub means no borrow.
module alu
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH = 5
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       alu_control,
  output logic [WIDTH-1:0] result,
  output logic [3:0]       alu_flags
);

  logic             sub;
  logic             arith;
  logic [WIDTH-1:0] bx;
  logic [WIDTH:0]   sum;

  always_comb begin
    sub   = (alu_control == OP_SUB);
    arith = (alu_control == OP_ADD) || sub;
    bx    = sub ? ~b : b;
    sum   = {1'b0, a} + {1'b0, bx} + {{WIDTH{1'b0}}, sub};
    result = '0;
    unique case (alu_control)
      OP_ADD, OP_SUB: result = sum[WIDTH-1:0];
      OP_AND:         result = a & b;
      OP_OR:          result = a | b;
      OP_XOR:         result = a ^ b;
      default:        result = '0;
    endcase
    alu_flags         = 4'b0000;
    alu_flags[FLAG_N] = result[WIDTH-1];
    alu_flags[FLAG_Z] = ~|result;
    alu_flags[FLAG_C] = arith & sum[WIDTH];
    alu_flags[FLAG_V] = arith & (a[WIDTH-1] == bx[WIDTH-1])
                      & (sum[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/rr_arbiter2.sv
// Two-way round-robin grant.
// Pointer names the favoured requester; moves only on accept.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       rr_ptr
);

  always_comb begin
    grant = 2'b00;
    unique case (1'b1)
      (valid == 2'b11): grant = rr_ptr ? 2'b10 : 2'b01;
      (valid == 2'b01): grant = 2'b01;
      (valid == 2'b10): grant = 2'b10;
      default:          grant = 2'b00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= 1'b0;
    end else if (accept) begin
      rr_ptr <= ~grant[1];
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters, round-robin.
// One op in flight: IDLE accept, EXEC capture, RESP drain.
module alu_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int WIDTH   = 5,
  parameter int NUM_OPS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [2:0]       req0_op,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [2:0]       req1_op,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [WIDTH-1:0] rsp0_result,
  output logic [3:0]       rsp0_flags,
  output logic             rsp0_err,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [WIDTH-1:0] rsp1_result,
  output logic [3:0]       rsp1_flags,
  output logic             rsp1_err,
  output logic             busy
);

  state_t           state_q;
  state_t           state_d;
  logic [1:0]       grant;
  logic             rr_ptr;
  logic             idle;
  logic             accept;
  logic             rsp_fire;
  logic             legal;
  logic             owner_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] alu_res;
  logic [3:0]       alu_flg;
  logic [1:0]       rsp_rdy;
  logic [1:0]       vld_q;
  logic [WIDTH-1:0] res_q [2];
  logic [3:0]       flg_q [2];
  logic [1:0]       err_q;

  assign idle    = (state_q == S_IDLE);
  assign accept  = idle & (|grant);
  assign rsp_rdy = {rsp1_ready, rsp0_ready};
  assign rsp_fire = (state_q == S_RESP) & rsp_rdy[owner_q];
  assign legal   = op_legal(op_q, NUM_OPS);

  // Ready is masked by reset so it drops the moment rst_n falls.
  assign req0_ready = rst_n & idle & grant[0];
  assign req1_ready = rst_n & idle & grant[1];
  assign busy       = ~idle;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .valid  ({req1_valid, req0_valid}),
    .accept (accept),
    .grant  (grant),
    .rr_ptr (rr_ptr)
  );

  alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .a           (a_q),
    .b           (b_q),
    .alu_control (op_q),
    .result      (alu_res),
    .alu_flags   (alu_flg)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (accept) state_d = S_EXEC;
      S_EXEC:  state_d = S_RESP;
      S_RESP:  if (rsp_fire) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
    end else if (accept) begin
      owner_q <= grant[1];
      a_q     <= grant[1] ? req1_a  : req0_a;
      b_q     <= grant[1] ? req1_b  : req0_b;
      op_q    <= grant[1] ? req1_op : req0_op;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q    <= 2'b00;
      res_q[0] <= '0;
      res_q[1] <= '0;
      flg_q[0] <= '0;
      flg_q[1] <= '0;
      err_q    <= 2'b00;
    end else begin
      if (state_q == S_EXEC) begin
        vld_q[owner_q] <= 1'b1;
        res_q[owner_q] <= legal ? alu_res : '0;
        flg_q[owner_q] <= legal ? alu_flg : 4'b0000;
        err_q[owner_q] <= ~legal;
      end
      if (rsp_fire) begin
        vld_q[owner_q] <= 1'b0;
      end
    end
  end

  assign rsp0_valid  = vld_q[0];
  assign rsp0_result = res_q[0];
  assign rsp0_flags  = flg_q[0];
  assign rsp0_err    = err_q[0];
  assign rsp1_valid  = vld_q[1];
  assign rsp1_result = res_q[1];
  assign rsp1_flags  = flg_q[1];
  assign rsp1_err    = err_q[1];

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: vector table, corner sequences,
// random ops, scoreboard checked on each response.
module tb_alu_arbiter;
  import alu_ctrl_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       req0_valid, req0_ready;
  logic [4:0] req0_a, req0_b;
  logic [2:0] req0_op;
  logic       req1_valid, req1_ready;
  logic [4:0] req1_a, req1_b;
  logic [2:0] req1_op;
  logic       rsp0_valid, rsp0_ready;
  logic [4:0] rsp0_result;
  logic [3:0] rsp0_flags;
  logic       rsp0_err;
  logic       rsp1_valid, rsp1_ready;
  logic [4:0] rsp1_result;
  logic [3:0] rsp1_flags;
  logic       rsp1_err;
  logic       busy;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  alu_arbiter #(.WIDTH(5), .NUM_OPS(5)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp0_result(rsp0_result), .rsp0_flags(rsp0_flags),
    .rsp0_err(rsp0_err),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp1_result(rsp1_result), .rsp1_flags(rsp1_flags),
    .rsp1_err(rsp1_err),
    .busy(busy)
  );

  typedef struct {
    int         id;
    logic [4:0] res;
    logic [3:0] flg;
    logic       err;
  } exp_t;

  typedef struct {
    int         id;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] op;
    logic [4:0] res;
    logic [3:0] flg;
    logic       err;
  } vec_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;

  task automatic chk(input string nm, input int act, input int want);
    tests++;
    if (act != want) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, want, $time);
    end
  endtask

  // Independent reference using integer arithmetic.
  function automatic exp_t model(input int id, input logic [4:0] a,
                                 input logic [4:0] b, input logic [2:0] op);
    exp_t e;
    int   ua, ub, sa, sbv, s, ss;
    logic c, v;
    ua = int'(a);
    ub = int'(b);
    sa = a[4] ? ua - 32 : ua;
    sbv = b[4] ? ub - 32 : ub;
    c = 1'b0;
    v = 1'b0;
    s = 0;
    ss = 0;
    case (op)
      3'd0: begin
        s = ua + ub; c = (s > 31);
        ss = sa + sbv; v = (ss > 15) || (ss < -16);
      end
      3'd1: begin
        s = ua - ub; c = (ua >= ub);
        ss = sa - sbv; v = (ss > 15) || (ss < -16);
      end
      3'd2: s = int'(a & b);
      3'd3: s = int'(a | b);
      3'd4: s = int'(a ^ b);
      default: s = 0;
    endcase
    e.id  = id;
    e.err = (op > 3'd4);
    e.res = e.err ? 5'd0 : s[4:0];
    e.flg = {e.res[4], e.res == 5'd0, c, v};
    if (e.err) e.flg = 4'b0000;
    return e;
  endfunction

  function automatic logic rdy(input int id);
    return (id == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic rspv(input int id);
    return (id == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [4:0] rspr(input int id);
    return (id == 0) ? rsp0_result : rsp1_result;
  endfunction

  task automatic drv(input int id, input logic v, input logic [4:0] a,
                     input logic [4:0] b, input logic [2:0] op);
    if (id == 0) begin
      req0_valid = v; req0_a = a; req0_b = b; req0_op = op;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b; req1_op = op;
    end
  endtask

  task automatic take(input int ch, input logic [4:0] r,
                      input logic [3:0] f, input logic er);
    exp_t e;
    if (sb.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_rsp: ch %0d result %0h, want no response",
               ch, r);
    end else begin
      e = sb.pop_front();
      chk("rsp", (ch << 10) | int'({r, f, er}),
          (e.id << 10) | int'({e.res, e.flg, e.err}));
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("rsp_onehot", int'(rsp0_valid & rsp1_valid), 0);
      if (rsp0_valid && rsp0_ready)
        take(0, rsp0_result, rsp0_flags, rsp0_err);
      if (rsp1_valid && rsp1_ready)
        take(1, rsp1_result, rsp1_flags, rsp1_err);
    end
  end

  task automatic issue(input int id, input logic [4:0] a,
                       input logic [4:0] b, input logic [2:0] op,
                       input exp_t e);
    int n;
    n = 0;
    drv(id, 1'b1, a, b, op);
    #1;
    while (!rdy(id) && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("ready", int'(rdy(id)), 1);
    if (!rdy(id)) begin
      drv(id, 1'b0, a, b, op);
      return;
    end
    @(posedge clk);
    sb.push_back(e);
    #1;
    drv(id, 1'b0, 5'($urandom), 5'($urandom), 3'($urandom));
    @(negedge clk);
    chk("exec_busy", int'(busy), 1);
    chk("exec_rspv", int'(rspv(id)), 0);
    chk("exec_ready", int'(req0_ready | req1_ready), 0);
    @(negedge clk);
    chk("resp_valid", int'(rspv(id)), 1);
    @(negedge clk);
    chk("done_valid", int'(rspv(id)), 0);
    chk("done_busy", int'(busy), 0);
    chk("hold_result", int'(rspr(id)), int'(e.res));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[12];
    exp_t e;

    tbl[0]  = '{0, 5'b00011, 5'b00101, OP_ADD, 5'b01000, 4'b0000, 1'b0};
    tbl[1]  = '{1, 5'b00010, 5'b00101, OP_SUB, 5'b11101, 4'b1000, 1'b0};
    tbl[2]  = '{0, 5'b01111, 5'b00001, OP_ADD, 5'b10000, 4'b1001, 1'b0};
    tbl[3]  = '{1, 5'b11111, 5'b00001, OP_ADD, 5'b00000, 4'b0110, 1'b0};
    tbl[4]  = '{0, 5'b10000, 5'b00001, OP_SUB, 5'b01111, 4'b0011, 1'b0};
    tbl[5]  = '{1, 5'b00101, 5'b00101, OP_SUB, 5'b00000, 4'b0110, 1'b0};
    tbl[6]  = '{0, 5'b10101, 5'b01110, OP_OR,  5'b11111, 4'b1000, 1'b0};
    tbl[7]  = '{1, 5'b11100, 5'b10101, OP_AND, 5'b10100, 4'b1000, 1'b0};
    tbl[8]  = '{0, 5'b01001, 5'b00110, OP_XOR, 5'b01111, 4'b0000, 1'b0};
    tbl[9]  = '{1, 5'b10101, 5'b10101, OP_XOR, 5'b00000, 4'b0100, 1'b0};
    tbl[10] = '{0, 5'b00111, 5'b00011, 3'b101, 5'b00000, 4'b0000, 1'b1};
    tbl[11] = '{1, 5'b11111, 5'b11111, 3'b111, 5'b00000, 4'b0000, 1'b1};

    rst_n = 1'b1;
    drv(0, 1'b0, 5'd0, 5'd0, 3'd0);
    drv(1, 1'b0, 5'd0, 5'd0, 3'd0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #1 rst_n = 1'b0;
    req0_valid = 1'b1;
    #2;
    chk("rst_busy", int'(busy), 0);
    chk("rst_ready0", int'(req0_ready), 0);
    chk("rst_valid", int'({rsp0_valid, rsp1_valid}), 0);
    chk("rst_result", int'({rsp0_result, rsp1_result}), 0);
    chk("rst_flags", int'({rsp0_flags, rsp1_flags}), 0);
    chk("rst_err", int'({rsp0_err, rsp1_err}), 0);
    req0_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 12; i++) begin
      e = '{tbl[i].id, tbl[i].res, tbl[i].flg, tbl[i].err};
      issue(tbl[i].id, tbl[i].a, tbl[i].b, tbl[i].op, e);
    end

    // Both valid with pointer at 0: req0 first, then req1.
    drv(0, 1'b1, 5'b01000, 5'b00001, OP_AND);
    drv(1, 1'b1, 5'b00101, 5'b00111, OP_OR);
    #1;
    chk("both_rdy0", int'(req0_ready), 1);
    chk("both_rdy1", int'(req1_ready), 0);
    @(posedge clk);
    e = '{0, 5'b00000, 4'b0100, 1'b0};
    sb.push_back(e);
    #1 drv(0, 1'b1, 5'd1, 5'd1, OP_ADD);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("rr_rdy1", int'(req1_ready), 1);
    chk("rr_rdy0", int'(req0_ready), 0);
    e = '{1, 5'b00111, 4'b0000, 1'b0};
    issue(1, 5'b00101, 5'b00111, OP_OR, e);
    issue(0, 5'd1, 5'd1, OP_ADD, model(0, 5'd1, 5'd1, OP_ADD));

    // Response backpressure on requester 0.
    rsp0_ready = 1'b0;
    drv(0, 1'b1, 5'b01001, 5'b00110, OP_XOR);
    #1 chk("stall_rdy0", int'(req0_ready), 1);
    @(posedge clk);
    e = '{0, 5'b01111, 4'b0000, 1'b0};
    sb.push_back(e);
    #1;
    drv(0, 1'b0, 5'd0, 5'd0, 3'd0);
    drv(1, 1'b1, 5'd6, 5'd3, OP_ADD);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", int'(rsp0_valid), 1);
      chk("stall_result", int'(rsp0_result), 15);
      chk("stall_rdy1", int'(req1_ready), 0);
      chk("stall_busy", int'(busy), 1);
      chk("stall_rsp1", int'(rsp1_valid), 0);
    end
    @(posedge clk);
    #1 rsp0_ready = 1'b1;
    @(negedge clk);
    issue(1, 5'd6, 5'd3, OP_ADD, model(1, 5'd6, 5'd3, OP_ADD));

    // Reset pulsed while an op sits in EXEC.
    drv(0, 1'b1, 5'd3, 5'd4, OP_ADD);
    #1 chk("rx_rdy0", int'(req0_ready), 1);
    @(posedge clk);
    sb.push_back(model(0, 5'd3, 5'd4, OP_ADD));
    @(negedge clk);
    chk("rx_exec_busy", int'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("rx_busy", int'(busy), 0);
    chk("rx_valid", int'({rsp0_valid, rsp1_valid}), 0);
    chk("rx_ready", int'({req0_ready, req1_ready}), 0);
    chk("rx_result", int'(rsp0_result), 0);
    sb.delete();
    @(posedge clk);
    #1 req0_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("rx_no_rsp", int'(rsp0_valid), 0);
      chk("rx_idle", int'(busy), 0);
    end
    issue(0, 5'd9, 5'd2, OP_SUB, model(0, 5'd9, 5'd2, OP_SUB));

    for (int i = 0; i < 30; i++) begin
      int         id;
      logic [4:0] a;
      logic [4:0] b;
      logic [2:0] op;
      id = int'($urandom_range(0, 1));
      a  = 5'($urandom);
      b  = 5'($urandom);
      op = 3'($urandom);
      issue(id, a, b, op, model(id, a, b, op));
    end

    @(negedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares the single 5-bit ALU (ALUControl 000 add, 001 sub, 010 and, 011 or, 100 xor; flags {N,Z,C,V}) between two independent requesters. It arbitrates round-robin and registers the operands into the ALU. It captures Result/ALUFlags and returns them on a per-requester response channel with valid/ready backpressure. One operation is in flight at a time.

Parameters:
WIDTH, 5, operand/result width; must equal the ALU width.
NUM_OPS, 5, legal op codes are 0..NUM_OPS-1; codes at or above NUM_OPS are illegal.

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid  in  1  requester 0 has an operation
req0_ready  out  1  arbiter accepts requester 0 this cycle
req0_a, req0_b  in  WIDTH  operands, requester 0
req0_op  in  3  ALUControl code, requester 0
req1_valid / req1_ready / req1_a / req1_b / req1_op  (same as requester 0, for requester 1)
rsp0_valid  out  1  response for requester 0 available
rsp0_ready  in  1  requester 0 consumes the response
rsp0_result  out  WIDTH  captured ALU Result
rsp0_flags  out  4  captured {N,Z,C,V}
rsp0_err  out  1  op code was illegal
rsp1_valid / rsp1_ready / rsp1_result / rsp1_flags / rsp1_err  (same, for requester 1)
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, rr_ptr=0.
  - All rsp*_valid=0, rsp*_result=0, rsp*_flags=0, rsp*_err=0, busy=0.
  - Operand/op registers=0.
  - An in-flight transaction is discarded; no response is produced for it after release.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - grant = requester with valid=1. If both are valid, grant goes to rr_ptr.
  - reqX_ready=1 only for the granted requester. Both ready=0 outside IDLE.
  - Ready depends combinationally on valid.
  - Handshake fires when valid&ready at the clock edge. Then: latch a, b, op and owner id; rr_ptr <= ~owner; state -> EXEC.
  - With no valid requester, stay in IDLE and leave rr_ptr unchanged.
- EXEC (one cycle):
  - The ALU sees the latched a/b/op.
  - Legal op: capture Result and ALUFlags into the owner's rsp registers, err=0.
  - Illegal op: result=0, flags=0, err=1.
  - Set rsp_valid(owner)=1; state -> RESP.
- RESP:
  - Hold rsp fields stable while rsp_valid=1.
  - When rsp_ready(owner)=1 at an edge: clear rsp_valid, state -> IDLE.
  - The non-owner rsp channel stays at valid=0 throughout.
- Latency: request accepted at edge N; rsp_valid=1 after edge N+1. If rsp_ready is already high, rsp_valid clears at edge N+2. The next acceptance is possible at edge N+3 (minimum 3 cycles per op).
- Input changes after the handshake have no effect on the in-flight op.
- A requester may hold valid through its own response; it is re-arbitrated against the other requester in IDLE.
- rr_ptr toggles only on an accepted handshake. A single lone requester can issue back-to-back.
- Arithmetic: none in this block. Result and flags are exactly the ALU outputs; no width extension.
- rsp fields keep their last value after rsp_valid falls, until overwritten by the next op for the same requester.

Decomposition:
- Package alu_ctrl_pkg:
  - op code localparams OP_ADD=0, OP_SUB=1, OP_AND=2, OP_OR=3, OP_XOR=4
  - state encodings S_IDLE, S_EXEC, S_RESP
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
- Sub-module rr_arbiter2: combinational 2-way grant from valid[1:0] plus registered rr_ptr with update-on-accept.
- The existing alu is instantiated unchanged.

Test Plan:
- Reset, then req0 add a=00011 b=00101 -> req0_ready=1 in the same cycle; rsp0_valid after 2 edges with result=01000, flags=0000, err=0.
- req1 sub a=00010 b=00101 -> rsp1_result=11101, flags=1000 (N=1, C=0 borrow).
- Both valid with rr_ptr=0: req0 and 01000&00001, req1 or 00101|00111 -> req0 served first (result 00000, flags 0100); rsp1 later gives 00111. The next simultaneous request favours req1.
- rsp0_ready held low 5 cycles after an xor of 01001^00110 -> rsp0_valid stays 1 and result stays 01111. req1_ready stays 0 and busy stays 1 until rsp0_ready=1.
- req0_op=101 -> rsp0_err=1, result=00000, flags=0000. The FSM returns to IDLE normally.
- rst_n pulsed low during EXEC -> busy, rsp*_valid and req*_ready drop immediately (req*_ready returns to 1 for a valid requester once in IDLE after release). No response appears after release; the next request completes normally.
